// File: rtl/mmu_seq.sv
// Pass sequencer for the MMU systolic array: weight load, latch, activation
// streaming and result collection, with abort and busy-cycle accounting.
module mmu_seq #(
  parameter int N        = 4,
  parameter int ROW_W    = 8,
  parameter int PIPE_LAT = 7
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ROW_W-1:0]       rows,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [31:0]            cycles,
  output logic                   w_rd_en,
  output logic [$clog2(N)-1:0]   w_rd_addr,
  output logic                   arr_w_shift,
  output logic                   arr_w_latch,
  output logic                   a_rd_en,
  output logic [ROW_W-1:0]       a_rd_addr,
  output logic                   arr_a_valid,
  output logic                   res_wr_en,
  output logic [ROW_W-1:0]       res_wr_addr
);

  localparam int KW = $clog2(N + 1);
  localparam int AW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_W_LATCH, S_FEED, S_DRAIN, S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [KW-1:0]       r_k, w_k_nxt;
  logic [ROW_W-1:0]    r_m, w_m_nxt;
  logic [ROW_W-1:0]    r_a, w_a_nxt;
  logic [31:0]         r_cnt;
  logic [PIPE_LAT-1:0] r_dly;
  logic                w_start_acc;
  logic                w_abort_eff;

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_m_nxt     = r_m;
    w_a_nxt     = r_a;
    w_start_acc = 1'b0;
    w_abort_eff = abort && (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        // abort beats a simultaneous start and leaves the sequencer idle
        if (start && !abort) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_LOAD_W;
          w_k_nxt     = '0;
          w_m_nxt     = rows;
        end
      end
      S_LOAD_W: begin
        if (r_k == KW'(N)) w_state_nxt = S_W_LATCH;
        else               w_k_nxt     = r_k + KW'(1);
      end
      S_W_LATCH: begin
        w_a_nxt     = '0;
        w_state_nxt = (r_m != '0) ? S_FEED : S_DONE;
      end
      S_FEED: begin
        if (r_a == r_m - ROW_W'(1)) w_state_nxt = S_DRAIN;
        else                        w_a_nxt     = r_a + ROW_W'(1);
      end
      S_DRAIN: begin
        if (res_wr_en && (res_wr_addr == r_m - ROW_W'(1))) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort_eff) w_state_nxt = S_IDLE;
  end

  assign res_wr_en = r_dly[PIPE_LAT-1];

  // Every output is a flop loaded from the next-state decode.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_m         <= '0;
      r_a         <= '0;
      r_cnt       <= '0;
      r_dly       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      cycles      <= '0;
      w_rd_en     <= 1'b0;
      w_rd_addr   <= '0;
      arr_w_shift <= 1'b0;
      arr_w_latch <= 1'b0;
      a_rd_en     <= 1'b0;
      a_rd_addr   <= '0;
      arr_a_valid <= 1'b0;
      res_wr_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_m         <= w_m_nxt;
      r_a         <= w_a_nxt;
      busy        <= (w_state_nxt != S_IDLE);
      w_rd_en     <= (w_state_nxt == S_LOAD_W) && (w_k_nxt != KW'(N));
      w_rd_addr   <= w_k_nxt[AW-1:0];
      arr_w_latch <= (w_state_nxt == S_W_LATCH);
      a_rd_en     <= (w_state_nxt == S_FEED);
      a_rd_addr   <= w_a_nxt;
      done        <= (w_state_nxt == S_DONE);
      aborted     <= w_abort_eff;
      if (w_abort_eff) begin
        arr_w_shift <= 1'b0;
        arr_a_valid <= 1'b0;
        r_dly       <= '0;
      end else begin
        arr_w_shift <= w_rd_en;
        arr_a_valid <= a_rd_en;
        r_dly[0]    <= arr_a_valid;
        for (int i = 1; i < PIPE_LAT; i++) r_dly[i] <= r_dly[i-1];
      end
      if (w_start_acc)    res_wr_addr <= '0;
      else if (res_wr_en) res_wr_addr <= res_wr_addr + ROW_W'(1);
      // r_cnt already counts the current busy cycle; +1 folds in the DONE cycle
      if (w_start_acc)             r_cnt <= 32'd1;
      else if (r_state != S_IDLE)  r_cnt <= r_cnt + 32'd1;
      if (w_state_nxt == S_DONE)   cycles <= r_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mmu_seq.sv
// Randomized bench for mmu_seq against a pass-timeline model built from the
// cycle rules of a pass (start at local cycle 0).
module tb_mmu_seq;
  localparam int N     = 4;
  localparam int ROW_W = 8;
  localparam int P     = 7;

  logic              sys_clk = 1'b0;
  logic              rst, start, abort;
  logic [ROW_W-1:0]  rows;
  logic              busy, done, aborted;
  logic [31:0]       cycles;
  logic              w_rd_en;
  logic [1:0]        w_rd_addr;
  logic              arr_w_shift, arr_w_latch, a_rd_en, arr_a_valid, res_wr_en;
  logic [ROW_W-1:0]  a_rd_addr, res_wr_addr;

  int n_tot = 0;
  int n_bad = 0;
  int exp_cyc = 0;

  mmu_seq #(.N(N), .ROW_W(ROW_W), .PIPE_LAT(P)) dut (
    .sys_clk(sys_clk), .rst(rst), .start(start), .abort(abort), .rows(rows),
    .busy(busy), .done(done), .aborted(aborted), .cycles(cycles),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .arr_w_shift(arr_w_shift),
    .arr_w_latch(arr_w_latch), .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
    .arr_a_valid(arr_a_valid), .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},    32'(busy),        32'd0);
    chk({tag, ".done"},    32'(done),        32'd0);
    chk({tag, ".aborted"}, 32'(aborted),     32'd0);
    chk({tag, ".cycles"},  cycles,           32'd0);
    chk({tag, ".w_en"},    32'(w_rd_en),     32'd0);
    chk({tag, ".w_addr"},  32'(w_rd_addr),   32'd0);
    chk({tag, ".shift"},   32'(arr_w_shift), 32'd0);
    chk({tag, ".latch"},   32'(arr_w_latch), 32'd0);
    chk({tag, ".a_en"},    32'(a_rd_en),     32'd0);
    chk({tag, ".a_addr"},  32'(a_rd_addr),   32'd0);
    chk({tag, ".valid"},   32'(arr_a_valid), 32'd0);
    chk({tag, ".res"},     32'(res_wr_en),   32'd0);
    chk({tag, ".r_addr"},  32'(res_wr_addr), 32'd0);
  endtask

  // One pass: m rows, abort in cycle ab (-1 none), clash = start+abort at 0,
  // sp1/sp2 extra start pulses, rc = cycle rows is changed to 9, gap = idle tail.
  task automatic run_scn(input int m, input int ab, input bit clash, input int sp1,
                         input int sp2, input int rc, input int gap, input bit noise);
    int  e, fin, last;
    bit  acc, live, completed, b;
    acc       = !clash;
    e         = (m > 0) ? N + 4 + P + m : N + 3;
    fin       = !acc ? 2 : ((ab >= 0) ? ab + 1 : e);
    last      = fin + gap - 1;
    completed = acc && (ab < 0);
    for (int t = 0; t <= last; t++) begin
      @(negedge sys_clk);
      live = acc && (t >= 1) && (t <= e) && ((ab < 0) || (t <= ab));
      chk($sformatf("busy@%0d", t), 32'(busy), 32'(live));
      b = live && (t >= 1) && (t <= N);
      chk($sformatf("w_rd_en@%0d", t), 32'(w_rd_en), 32'(b));
      if (b) chk($sformatf("w_rd_addr@%0d", t), 32'(w_rd_addr), 32'(t - 1));
      chk($sformatf("shift@%0d", t), 32'(arr_w_shift), 32'(live && (t >= 2) && (t <= N + 1)));
      chk($sformatf("latch@%0d", t), 32'(arr_w_latch), 32'(live && (t == N + 2)));
      b = live && (t >= N + 3) && (t <= N + 2 + m);
      chk($sformatf("a_rd_en@%0d", t), 32'(a_rd_en), 32'(b));
      if (b) chk($sformatf("a_rd_addr@%0d", t), 32'(a_rd_addr), 32'(t - (N + 3)));
      chk($sformatf("a_valid@%0d", t), 32'(arr_a_valid), 32'(live && (t >= N + 4) && (t <= N + 3 + m)));
      b = live && (t >= N + 4 + P) && (t <= N + 3 + P + m);
      chk($sformatf("res_wr_en@%0d", t), 32'(res_wr_en), 32'(b));
      if (b) chk($sformatf("res_wr_addr@%0d", t), 32'(res_wr_addr), 32'(t - (N + 4 + P)));
      chk($sformatf("done@%0d", t), 32'(done), 32'(live && (t == e)));
      chk($sformatf("aborted@%0d", t), 32'(aborted), 32'(acc && (ab >= 0) && (t == ab + 1)));
      if (!(completed && t == e))
        chk($sformatf("cycles@%0d", t), cycles, (completed && t > e) ? 32'(e) : 32'(exp_cyc));
      start = (t == 0) || (t == sp1) || (t == sp2) || (noise && live && ($urandom_range(0, 3) == 0));
      abort = (clash && t == 0) || (t == ab);
      if (t == 0)       rows = ROW_W'(m);
      else if (t == rc) rows = ROW_W'(9);
      else if (noise)   rows = ROW_W'($urandom);
    end
    if (completed) exp_cyc = e;
  endtask

  initial begin
    int m, e, ab, gap;
    bit clash;
    rst = 1'b1; start = 1'b0; abort = 1'b0; rows = '0;
    repeat (2) @(negedge sys_clk);
    chk_all_zero("reset");
    rst = 1'b0;

    run_scn(3, -1, 1'b0, -1, -1, -1, 2, 1'b0);
    run_scn(0, -1, 1'b0, -1, -1, -1, 2, 1'b0);
    run_scn(3, 12, 1'b0, -1, -1, -1, 2, 1'b0);
    run_scn(3, -1, 1'b0,  5, 10,  4, 1, 1'b0);
    run_scn(3, -1, 1'b1, -1, -1, -1, 1, 1'b0);
    run_scn(5, -1, 1'b0, -1, -1, -1, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      m     = $urandom_range(0, 6);
      e     = (m > 0) ? N + 4 + P + m : N + 3;
      ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, e - 1)) : -1;
      clash = ($urandom_range(0, 7) == 0);
      gap   = $urandom_range(1, 3);
      run_scn(m, ab, clash, -1, -1, -1, gap, 1'b1);
    end

    @(negedge sys_clk);
    start = 1'b1; abort = 1'b0; rows = ROW_W'(3);
    @(negedge sys_clk);
    start = 1'b0;
    repeat (8) @(negedge sys_clk);
    chk("pre_rst.busy", 32'(busy), 32'd1);
    chk("pre_rst.a_rd_en", 32'(a_rd_en), 32'd1);
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_async");
    @(negedge sys_clk);
    rst = 1'b0;
    exp_cyc = 0;
    run_scn(2, -1, 1'b0, -1, -1, -1, 2, 1'b0);

    start = 1'b0; abort = 1'b0;
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/mmu_seq.md
# mmu_seq

Sequencer for the matrix multiply unit's systolic datapath. It sits between the AXI-Lite register file of the MMU and the N×N array plus its weight, activation and result buffers. One `start` runs one complete pass: load the weight tile, latch it, stream M activation rows, collect M result rows, then report `done`.

## Interface
- `N`, 4: array dimension (weight rows per tile); ≥2.
- `ROW_W`, 8: width of row count and row addresses; M ≤ 2^ROW_W−1.
- `PIPE_LAT`, 7: cycles from `arr_a_valid` for a row to that row's result being valid (2N−1 for default array).

Ports:
- `sys_clk` in 1: sole clock, all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin pass; sampled only in IDLE.
- `abort` in 1: cancel pass in any non-IDLE state.
- `rows` in ROW_W: M, activation rows for this pass; latched at accepted start.
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle pulse at successful completion.
- `aborted` out 1: one-cycle pulse when an abort takes effect.
- `cycles` out 32: busy-cycle count of the last completed pass; holds until the next completion.
- `w_rd_en` out 1 / `w_rd_addr` out $clog2(N): weight buffer read (1-cycle read latency).
- `arr_w_shift` out 1: shift weight row into array (= `w_rd_en` delayed 1).
- `arr_w_latch` out 1: transfer shifted weights to active registers.
- `a_rd_en` out 1 / `a_rd_addr` out ROW_W: activation buffer read (1-cycle latency).
- `arr_a_valid` out 1: activation row valid at array input (= `a_rd_en` delayed 1).
- `res_wr_en` out 1 / `res_wr_addr` out ROW_W: result buffer write strobe and row address.

## Operation
- States: IDLE, LOAD_W, W_LATCH, FEED, DRAIN, DONE.
- IDLE:
  - `start`=1 and `abort`=0 → latch `rows`, clear the internal row/weight counters and the busy counter, go to LOAD_W.
  - `start` and `abort` together in IDLE → `abort` wins: stay IDLE, no `aborted` pulse.
- LOAD_W lasts N+1 cycles, with counter k=0..N:
  - `w_rd_en`=1 and `w_rd_addr`=k while k<N.
  - `arr_w_shift` is the registered `w_rd_en`.
  - After k=N → W_LATCH.
- W_LATCH is one cycle: `arr_w_latch`=1.
  - Next state is FEED if M>0, else DONE.
- FEED lasts M cycles: `a_rd_en`=1, `a_rd_addr`=0..M−1 → DRAIN.
- `res_wr_en` is `arr_a_valid` passed through a PIPE_LAT-deep delay line.
  - `res_wr_addr` starts at 0 and increments after each write.
- DRAIN holds until the M-th `res_wr_en` has been issued → DONE.
- DONE is one cycle:
  - `done`=1.
  - `cycles` ← busy count, including the DONE cycle.
  - Next state is IDLE.
- `start` outside IDLE is ignored. Changes on `rows` while busy are ignored.
- `abort` in any non-IDLE state:
  - Next cycle: IDLE.
  - `aborted`=1 for 1 cycle.
  - All strobes and delay-line stages are cleared in that same next cycle.
  - `done` is not asserted and `cycles` is not updated.
- Reset: state IDLE; every output 0, including `cycles` and all addresses; delay lines cleared. Reset mid-pass discards the pass silently (no `done`, no `aborted`).

## Timing
Cycle numbers below are relative to the edge sampling `start` (cycle 0):
- `busy` is high from cycle 1 through the DONE cycle.
- `w_rd_en`: cycles 1..N. `arr_w_shift`: cycles 2..N+1.
- `arr_w_latch`: cycle N+2.
- `a_rd_en`: N+3..N+2+M. `arr_a_valid`: N+4..N+3+M.
- `res_wr_en`: N+4+PIPE_LAT..N+3+PIPE_LAT+M.
- `done`: cycle N+4+PIPE_LAT+M. If M=0, `done` is at cycle N+3.
- `cycles` = cycle index of `done`.
- The earliest next `start` is accepted the cycle after `done`.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- N=4, PIPE_LAT=7, M=3, start at cycle 0 → all of the following:
  - `w_rd_en` cycles 1–4, addresses 0–3; `arr_w_shift` cycles 2–5; `arr_w_latch` cycle 6.
  - `a_rd_en` cycles 7–9, addresses 0–2; `arr_a_valid` cycles 8–10.
  - `res_wr_en` cycles 15–17, addresses 0–2.
  - `done` at cycle 18; `cycles`=18.
- M=0 → `arr_w_latch` at cycle 6, no `a_rd_en` or `res_wr_en`, `done` at cycle 7, `cycles`=7.
- `abort` at cycle 12 of the M=3 run → `aborted` at cycle 13 and `busy`=0 from cycle 13; no `res_wr_en`; no `done`; `cycles` keeps its previous value.
- `start` pulsed at cycles 5 and 10 during the M=3 run, and `rows` changed to 9 at cycle 4 → timeline is identical to scenario 1.
- `start`+`abort` together in IDLE → stays IDLE, no pulses. Then `start` alone → normal run.
- `rst` asserted at cycle 9 of a run → all outputs 0 immediately (asynchronous). After `rst` is released, a fresh M=2 run gives `done` at cycle 17 relative to its own start.
